// File: rtl/roulette_spinner_if.sv
// Result/handshake bundle between the roulette spinner and its consumer.
// The consumer drives start; the spinner drives everything else.
interface roulette_spinner_if;
  logic       start;
  logic [4:0] spin_pos;
  logic [4:0] result;
  logic       busy;
  logic       done;

  modport master (output start, input spin_pos, result, busy, done);
  modport slave  (input start, output spin_pos, result, busy, done);
endinterface

// File: rtl/roulette_spinner.sv
// Decelerating roulette wheel: each spin step waits one cycle longer than the last.
// The step count comes from a free-running 16-bit LFSR sampled at spin start.
module roulette_spinner #(
  parameter int          MAX_VALUE = 31,
  parameter int          MIN_STEPS = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               clk,
  input  logic               resetn,
  roulette_spinner_if.slave  bus
);

  // Counter width must hold MIN_STEPS+31 steps and the interval one past that.
  localparam int CW = $clog2(MIN_STEPS + 32);
  localparam logic [4:0] MAXV = 5'(MAX_VALUE);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SPIN = 2'b01
  } state_t;

  state_t          state, stateNxt;
  logic [15:0]     lfsr;
  logic [CW-1:0]   stepsLeft, interval, waitCnt;
  logic [4:0]      spinPos, resultQ, nextPos;
  logic            busyQ, doneQ;
  logic            stepNow, lastStep;

  assign nextPos  = (spinPos == MAXV) ? 5'd0 : spinPos + 5'd1;
  assign stepNow  = (waitCnt == interval - CW'(1));
  assign lastStep = (state == SPIN) && stepNow && (stepsLeft == CW'(1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    case (state)
      IDLE:    if (bus.start) stateNxt = SPIN;
      SPIN:    if (lastStep)  stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lfsr      <= LFSR_SEED;
      stepsLeft <= '0;
      interval  <= '0;
      waitCnt   <= '0;
      spinPos   <= '0;
      resultQ   <= '0;
      busyQ     <= 1'b0;
      doneQ     <= 1'b0;
    end else begin
      lfsr  <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      doneQ <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            stepsLeft <= CW'(MIN_STEPS) + CW'(lfsr[4:0]);
            interval  <= CW'(1);
            waitCnt   <= '0;
            busyQ     <= 1'b1;
          end
        end
        SPIN: begin
          if (stepNow) begin
            spinPos   <= nextPos;
            stepsLeft <= stepsLeft - CW'(1);
            interval  <= interval + CW'(1);
            waitCnt   <= '0;
            if (lastStep) begin
              resultQ <= nextPos;
              doneQ   <= 1'b1;
              busyQ   <= 1'b0;
            end
          end else begin
            waitCnt <= waitCnt + CW'(1);
          end
        end
        default: busyQ <= 1'b0;
      endcase
    end
  end

  assign bus.spin_pos = spinPos;
  assign bus.result   = resultQ;
  assign bus.busy     = busyQ;
  assign bus.done     = doneQ;

endmodule

// File: tb/tb_roulette_spinner.sv
// Directed/table bench for roulette_spinner: two instances (MAX_VALUE 31 and 9)
// share one start, checked against constants and a triangular-number timing model.
module tb_roulette_spinner;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  logic start = 1'b0;
  bit   chkEn = 1'b0;
  int   vecs = 0, errs = 0, doneCnt = 0;

  always #5 clk = ~clk;

  roulette_spinner_if ifA ();
  roulette_spinner_if ifB ();
  assign ifA.start = start;
  assign ifB.start = start;

  roulette_spinner #(.MAX_VALUE(31), .MIN_STEPS(16), .LFSR_SEED(16'hACE1)) dutA (
    .clk(clk), .resetn(resetn), .bus(ifA));
  roulette_spinner #(.MAX_VALUE(9), .MIN_STEPS(16), .LFSR_SEED(16'hACE1)) dutB (
    .clk(clk), .resetn(resetn), .bus(ifB));

  // Reference model: step i lands i(i+1)/2 edges after the start edge.
  logic [15:0] mLfsr;
  bit          mBusy, mDone;
  int          mT, mI, mN, mPosA, mPosB, mResA, mResB;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mLfsr <= 16'hACE1; mBusy <= 0; mDone <= 0;
      mT <= 0; mI <= 0; mN <= 0;
      mPosA <= 0; mPosB <= 0; mResA <= 0; mResB <= 0;
    end else begin
      mLfsr <= {mLfsr[14:0], mLfsr[15] ^ mLfsr[13] ^ mLfsr[12] ^ mLfsr[10]};
      mDone <= 0;
      if (!mBusy) begin
        if (start) begin
          mBusy <= 1; mN <= 16 + int'(mLfsr[4:0]); mT <= 0; mI <= 0;
        end
      end else begin
        mT <= mT + 1;
        if (mT + 1 == (mI + 1) * (mI + 2) / 2) begin
          mI    <= mI + 1;
          mPosA <= (mPosA == 31) ? 0 : mPosA + 1;
          mPosB <= (mPosB == 9)  ? 0 : mPosB + 1;
          if (mI + 1 == mN) begin
            mResA <= (mPosA == 31) ? 0 : mPosA + 1;
            mResB <= (mPosB == 9)  ? 0 : mPosB + 1;
            mDone <= 1; mBusy <= 0;
          end
        end
      end
    end
  end

  task automatic cmp(input string nm, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d, want %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Every wait goes through here so the model is compared on each cycle.
  task automatic tick();
    @(negedge clk);
    if (chkEn) begin
      cmp("posA",  int'(ifA.spin_pos), mPosA);
      cmp("posB",  int'(ifB.spin_pos), mPosB);
      cmp("resA",  int'(ifA.result),   mResA);
      cmp("resB",  int'(ifB.result),   mResB);
      cmp("busyA", int'(ifA.busy),     int'(mBusy));
      cmp("busyB", int'(ifB.busy),     int'(mBusy));
      cmp("doneA", int'(ifA.done),     int'(mDone));
      cmp("doneB", int'(ifB.done),     int'(mDone));
      cmp("rangeB", int'(ifB.spin_pos <= 5'd9), 1);
    end
    if (ifA.done) doneCnt++;
  endtask

  // Reset, then start=1 on exactly the first edge after release; returns at the negedge after it.
  task automatic resetAndStart(input bit holdStart);
    resetn = 1'b0; start = 1'b0;
    tick(); tick();
    resetn = 1'b1; start = 1'b1;
    tick();
    if (!holdStart) start = 1'b0;
    doneCnt = 0;
  endtask

  typedef struct {
    int d; int posA; int posB; int busy; int done; int resA; int resB;
  } vec_t;
  vec_t tbl[10];

  task automatic runTable();
    int cur;
    resetAndStart(1'b0);
    cur = 0;
    for (int v = 0; v < 10; v++) begin
      while (cur < tbl[v].d) begin tick(); cur++; end
      cmp($sformatf("tbl%0d.posA", tbl[v].d),  int'(ifA.spin_pos), tbl[v].posA);
      cmp($sformatf("tbl%0d.posB", tbl[v].d),  int'(ifB.spin_pos), tbl[v].posB);
      cmp($sformatf("tbl%0d.busyA", tbl[v].d), int'(ifA.busy),     tbl[v].busy);
      cmp($sformatf("tbl%0d.busyB", tbl[v].d), int'(ifB.busy),     tbl[v].busy);
      cmp($sformatf("tbl%0d.doneA", tbl[v].d), int'(ifA.done),     tbl[v].done);
      cmp($sformatf("tbl%0d.doneB", tbl[v].d), int'(ifB.done),     tbl[v].done);
      cmp($sformatf("tbl%0d.resA", tbl[v].d),  int'(ifA.result),   tbl[v].resA);
      cmp($sformatf("tbl%0d.resB", tbl[v].d),  int'(ifB.result),   tbl[v].resB);
    end
    cmp("tblDoneCnt", doneCnt, 1);
  endtask

  initial begin
    int fin, lowCnt, cyc;
    bit ok;

    // N = 16 + (16'hACE1 & 5'h1f) = 17; step i at edge i(i+1)/2 after start.
    tbl[0] = '{0,   0,  0, 1, 0,  0, 0};
    tbl[1] = '{1,   1,  1, 1, 0,  0, 0};
    tbl[2] = '{2,   1,  1, 1, 0,  0, 0};
    tbl[3] = '{3,   2,  2, 1, 0,  0, 0};
    tbl[4] = '{6,   3,  3, 1, 0,  0, 0};
    tbl[5] = '{45,  9,  9, 1, 0,  0, 0};
    tbl[6] = '{55, 10,  0, 1, 0,  0, 0};
    tbl[7] = '{152, 16, 6, 1, 0,  0, 0};
    tbl[8] = '{153, 17, 7, 0, 1, 17, 7};
    tbl[9] = '{154, 17, 7, 0, 0, 17, 7};

    #1 resetn = 1'b0;
    #1 chkEn = 1'b1;
    cmp("rstPosA",  int'(ifA.spin_pos), 0);
    cmp("rstResA",  int'(ifA.result),   0);
    cmp("rstBusyA", int'(ifA.busy),     0);
    cmp("rstDoneA", int'(ifA.done),     0);

    runTable();

    // Start pulses during the spin must not disturb it.
    resetAndStart(1'b0);
    fin = -1;
    for (int c = 1; c <= 200; c++) begin
      start = (c % 7 == 3);
      tick();
      if (ifA.done && fin < 0) begin
        fin = c;
        cmp("pulseResA", int'(ifA.result), 17);
        cmp("pulseResB", int'(ifB.result), 7);
      end
    end
    start = 1'b0;
    cmp("pulseFinish", fin, 153);
    cmp("pulseDoneCnt", doneCnt, 1);

    // start held high: back-to-back spins with a single idle cycle.
    resetAndStart(1'b1);
    ok = 1'b0;
    for (int c = 0; c < 400 && !ok; c++) begin tick(); ok = ifA.done; end
    cmp("hold1Done", int'(ok), 1);
    lowCnt = 1;
    ok = 1'b0;
    for (int c = 0; c < 10 && !ok; c++) begin
      tick();
      if (ifA.busy) ok = 1'b1; else lowCnt++;
    end
    cmp("holdGapLow", lowCnt, 1);
    cmp("hold2StartPos", int'(ifA.spin_pos), 17);
    ok = 1'b0;
    for (int c = 0; c < 3000 && !ok; c++) begin tick(); ok = ifA.done; end
    start = 1'b0;
    cmp("hold2Done", int'(ok), 1);
    cmp("hold2ResA", int'(ifA.result), mResA);
    cmp("hold2ResB", int'(ifB.result), mResB);

    // Asynchronous reset at step 5 (edge +15), then the first spin must replay exactly.
    resetAndStart(1'b0);
    repeat (15) tick();
    cmp("step5PosA", int'(ifA.spin_pos), 5);
    #2 resetn = 1'b0;
    #1;
    cmp("arstPosA",  int'(ifA.spin_pos), 0);
    cmp("arstPosB",  int'(ifB.spin_pos), 0);
    cmp("arstResA",  int'(ifA.result),   0);
    cmp("arstBusyA", int'(ifA.busy),     0);
    cmp("arstBusyB", int'(ifB.busy),     0);
    cmp("arstDoneA", int'(ifA.done),     0);
    doneCnt = 0;
    repeat (3) tick();
    cmp("arstNoDone", doneCnt, 0);
    runTable();

    // Random start timing against the model.
    doneCnt = 0;
    cyc = 0;
    while (doneCnt < 60 && cyc < 60000) begin
      start = ($urandom_range(0, 7) == 0);
      tick();
      cyc++;
    end
    start = 1'b0;
    cmp("randSpins", doneCnt, 60);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
